// File: rtl/heartbeat_gen.sv
// heartbeat_gen: seven-segment animation generator.
// Step-rate prescaled pattern sequencer, one byte per digit.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         1 = animate, 0 = hold tick and step
//   mode       00 heartbeat, 01 sweep, 10 blink, 11 blank
//   rate_sel   step length = TICKS << rate_sel clocks
//   seg_out    digit i at [8i+7:8i], active-low, bit7 = dp
//   step_pulse one-cycle pulse per step advance
//   beat       one-cycle pulse when step wraps to 0
module heartbeat_gen #(
  parameter int DIGITS = 6,
  parameter int TICKS  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [1:0]          rate_sel,
  output logic [8*DIGITS-1:0] seg_out,
  output logic                step_pulse,
  output logic                beat
);

  localparam int TW = $clog2(TICKS * 8);
  localparam int SW = $clog2(DIGITS + 1);
  localparam int H  = DIGITS / 2;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [7:0] SEG_ALL  = 8'h80;
  localparam logic [7:0] SEG_RGT  = 8'hF9;
  localparam logic [7:0] SEG_LFT  = 8'hCF;

  typedef enum logic [1:0] {
    M_HEART = 2'b00,
    M_SWEEP = 2'b01,
    M_BLINK = 2'b10,
    M_BLANK = 2'b11
  } mode_e;

  logic [TW-1:0]       tick_q, tick_d;
  logic [SW-1:0]       step_q, step_d;
  mode_e               mode_q, mode_d;
  logic [8*DIGITS-1:0] seg_q, seg_d;
  logic                pulse_q, pulse_d;
  logic                beat_q, beat_d;

  logic [TW-1:0]       term;
  logic [SW-1:0]       last_step;
  mode_e               mode_in;

  assign mode_in = mode_e'(mode);

  // Terminal tick follows rate_sel live; a shrink below the
  // current count is caught by the >= compare next cycle.
  always_comb begin
    term = TW'((TICKS << rate_sel) - 1);
  end

  // Last step index of the active pattern (period - 1).
  always_comb begin
    last_step = '0;
    unique case (mode_q)
      M_HEART: last_step = SW'(2 * (H - 1) - 1);
      M_SWEEP: last_step = SW'(DIGITS - 1);
      M_BLINK: last_step = SW'(1);
      M_BLANK: last_step = '0;
      default: last_step = '0;
    endcase
  end

  // Sequencer: mode change beats enable, enable beats advance.
  always_comb begin
    tick_d  = tick_q;
    step_d  = step_q;
    mode_d  = mode_in;
    pulse_d = 1'b0;
    beat_d  = 1'b0;
    if (mode_in != mode_q) begin
      tick_d = '0;
      step_d = '0;
    end else if (en) begin
      if (tick_q >= term) begin
        tick_d  = '0;
        pulse_d = 1'b1;
        if (step_q >= last_step) begin
          step_d = '0;
          beat_d = 1'b1;
        end else begin
          step_d = step_q + SW'(1);
        end
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  // Pattern decode of the registered (step, mode_q).
  always_comb begin
    int s;
    int k;
    seg_d = {DIGITS{SEG_OFF}};
    s     = int'(step_q);
    k     = (s < H) ? s : (2 * (H - 1) - s);
    unique case (mode_q)
      M_HEART: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (i == H + k) begin
            seg_d[8*i +: 8] = SEG_RGT;
          end else if (i == H - 1 - k) begin
            seg_d[8*i +: 8] = SEG_LFT;
          end
        end
      end
      M_SWEEP: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (i == DIGITS - 1 - s) begin
            seg_d[8*i +: 8] = SEG_ALL;
          end
        end
      end
      M_BLINK: begin
        if (s == 0) begin
          seg_d = {DIGITS{SEG_ALL}};
        end
      end
      M_BLANK: begin
        seg_d = {DIGITS{SEG_OFF}};
      end
      default: begin
        seg_d = {DIGITS{SEG_OFF}};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q  <= '0;
      step_q  <= '0;
      mode_q  <= M_HEART;
      seg_q   <= {DIGITS{SEG_OFF}};
      pulse_q <= 1'b0;
      beat_q  <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
      seg_q   <= seg_d;
      pulse_q <= pulse_d;
      beat_q  <= beat_d;
    end
  end

  assign seg_out    = seg_q;
  assign step_pulse = pulse_q;
  assign beat       = beat_q;

endmodule

// File: doc/heartbeat_gen.md
# heartbeat_gen

Parametrised seven-segment animation generator, the next generation of the fixed 6-digit heartbeat circuit. Drives DIGITS display digits from one flat registered bus, with run-time selectable pattern mode (heartbeat, sweep, blink, blank), step-rate prescaling, pause, and a per-period beat strobe. Sits between the system clock domain and the display multiplexer, one byte per digit.

## Interface
- DIGITS, 6: number of digits; even, 4..8.
- TICKS, 10: base clocks per animation step; ≥1.

- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  1 = animate; 0 = hold tick counter and step, outputs frozen.
- mode  in  2  00 heartbeat, 01 sweep, 10 blink, 11 blank.
- rate_sel  in  2  step length = TICKS << rate_sel clocks (×1, ×2, ×4, ×8).
- seg_out  out  8*DIGITS  digit i at bits [8i+7:8i]; digit 0 rightmost; per byte bit7=dp, bit6..0=g..a; active-low (0 lights); blank = 8'hFF.
- step_pulse  out  1  one-cycle pulse on each step advance.
- beat  out  1  one-cycle pulse when the step index wraps to 0.

## Operation
- Registers: tick counter (width $clog2(TICKS*8)), step index, mode_q, seg_out, step_pulse, beat.
- Tick: when en=1, tick increments; at tick == (TICKS<<rate_sel)-1 it clears and step advances (step_pulse=1). rate_sel change mid-step: compare uses new value; if tick already ≥ new terminal, advance on the next cycle and clear.
- Step period P per mode: heartbeat P = 2(H-1), H = DIGITS/2; sweep P = DIGITS; blink P = 2; blank P = 1. Step wraps P-1 → 0 and asserts beat with that step_pulse.
- Heartbeat decode: k = step for step < H, else k = 2(H-1) - step (ping-pong 0..H-1..1). Digit H+k = 8'hF9 (segments b,c), digit H-1-k = 8'hCF (segments e,f), all others 8'hFF.
- Sweep: digit DIGITS-1-step = 8'h80 (segments a–g), others 8'hFF.
- Blink: step 0 all digits 8'h80; step 1 all 8'hFF.
- Blank: all 8'hFF; tick still counts, beat pulses every step.
- Mode change: mode sampled each cycle into mode_q; when mode != mode_q, tick and step clear to 0 that cycle, no step_pulse/beat; new pattern appears at step 0.
- en=0 has priority over advance; mode change still clears counters while en=0.

## Timing
- Reset (rst=1 at edge): tick=0, step=0, mode_q=00, seg_out all 8'hFF, step_pulse=0, beat=0.
- seg_out is a registered decode of (step, mode_q): valid one cycle after step/mode_q update. First cycle after reset release: seg_out = step-0 pattern of the current mode (one cycle delayed by mode_q load if mode≠00).
- step_pulse/beat registered, asserted in the same cycle step holds its new value; seg_out shows that step one cycle later.
- TICKS=1, rate_sel=0: step advances every enabled cycle, step_pulse held high.
- Reset mid-step overrides everything, including pending advance and mode change.

## Test plan
- Reset: DIGITS=6, TICKS=10, rst held 3 cycles -> seg_out=48'hFFFF_FFFF_FFFF, step_pulse=beat=0; after release seg_out=48'hFFFF_F9CF_FFFF.
- Heartbeat sequence, mode=00, rate_sel=0 -> every 10 clocks seg_out cycles FFFF_F9CF_FFFF, FFF9_FFFF_CFFF, F9FF_FFFF_FFCF, FFF9_FFFF_CFFF, repeat; beat once every 40 clocks on wrap to step 0.
- Rate: rate_sel=10 -> step_pulse spacing 40 clocks; rate_sel 11→00 mid-step with tick=25 -> advance next cycle, then 10-clock spacing.
- Sweep/blink: mode=01 -> 8'h80 moves digit 5→0, beat every 60 clocks; mode=10 -> all 8'h80 / all 8'hFF alternating every 10 clocks.
- Pause and mode switch: en=0 for 37 clocks mid-step -> seg_out and tick frozen, no pulses, resumes with remaining count; mode 00→01 at step 2 -> counters clear, no beat, sweep step 0 (digit 5 = 8'h80) shown.
- Parameter sweep: DIGITS=4 and 8, TICKS=1 -> heartbeat period 2 and 6 steps respectively, step_pulse constant high, patterns per decode rule.
